// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stack_ctrl
// Purpose : 8051 stack-pointer owner; sequences PUSH/POP/LCALL/RET requests
//           into single-byte cycles on the internal data RAM port.
// Revision: 1.0 - initial release
// ============================================================================
module stack_ctrl #(
    parameter logic [7:0] SP_RESET = 8'h07,
    parameter int         RAM_AW   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [15:0]       push_data,
    input  logic              sp_wr_en,
    input  logic [7:0]        sp_wr_data,
    output logic [7:0]        sp,
    output logic              op_done,
    output logic [15:0]       pop_data,
    output logic              stk_err,
    output logic              ram_en,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam logic [8:0] c_RAM_DEPTH = 9'(1 << RAM_AW);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_LO = 3'd1,
        S_PUSH_HI = 3'd2,
        S_POP_HI  = 3'd3,
        S_POP_LO  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sp;
    logic        r_is16;
    logic [15:0] r_pdata;
    logic [15:0] r_pop_data;
    logic        r_stk_err;

    logic [7:0]  w_sp_inc;
    logic [7:0]  w_sp_dec;
    logic        w_push;
    logic        w_pop;
    logic        w_push_oor;
    logic        w_pop_oor;
    logic [7:0]  w_rbyte;

    assign w_sp_inc   = r_sp + 8'd1;
    assign w_sp_dec   = r_sp - 8'd1;
    assign w_push     = (r_state == S_PUSH_LO) || (r_state == S_PUSH_HI);
    assign w_pop      = (r_state == S_POP_HI) || (r_state == S_POP_LO);
    assign w_push_oor = ({1'b0, w_sp_inc} >= c_RAM_DEPTH);
    assign w_pop_oor  = ({1'b0, r_sp} >= c_RAM_DEPTH);
    assign w_rbyte    = w_pop_oor ? 8'h00 : ram_rdata;

    // Strobes gated by rst_n so a reset cycle never touches the RAM.
    assign ram_en       = rst_n & (w_push | w_pop);
    assign ram_write_en = rst_n & w_push & ~w_push_oor;
    assign ram_read_en  = rst_n & w_pop & ~w_pop_oor;
    assign ram_addr     = w_push ? w_sp_inc[RAM_AW-1:0] :
                          w_pop  ? r_sp[RAM_AW-1:0]     : '0;
    assign ram_wdata    = (r_state == S_PUSH_LO) ? r_pdata[7:0]  :
                          (r_state == S_PUSH_HI) ? r_pdata[15:8] : 8'h00;

    assign op_ready = (r_state == S_IDLE) & ~sp_wr_en;
    assign op_done  = (r_state == S_DONE);
    assign sp       = r_sp;
    assign pop_data = r_pop_data;
    assign stk_err  = r_stk_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sp       <= SP_RESET;
            r_is16     <= 1'b0;
            r_pdata    <= 16'h0000;
            r_pop_data <= 16'h0000;
            r_stk_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sp_wr_en) begin
                        r_sp      <= sp_wr_data;
                        r_stk_err <= 1'b0;
                    end else if (op_valid) begin
                        r_is16  <= op_code[1];
                        r_pdata <= push_data;
                        if (op_code == 2'b01) begin
                            r_pop_data[15:8] <= 8'h00;
                        end
                        if (!op_code[0]) begin
                            r_state <= S_PUSH_LO;
                        end else if (op_code[1]) begin
                            r_state <= S_POP_HI;
                        end else begin
                            r_state <= S_POP_LO;
                        end
                    end
                end
                S_PUSH_LO: begin
                    r_sp <= w_sp_inc;
                    if (w_push_oor) begin
                        r_stk_err <= 1'b1;
                    end
                    r_state <= r_is16 ? S_PUSH_HI : S_DONE;
                end
                S_PUSH_HI: begin
                    r_sp <= w_sp_inc;
                    if (w_push_oor) begin
                        r_stk_err <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_POP_HI: begin
                    r_pop_data[15:8] <= w_rbyte;
                    r_sp             <= w_sp_dec;
                    if (w_pop_oor) begin
                        r_stk_err <= 1'b1;
                    end
                    r_state <= S_POP_LO;
                end
                S_POP_LO: begin
                    r_pop_data[7:0] <= w_rbyte;
                    r_sp            <= w_sp_dec;
                    if (w_pop_oor) begin
                        r_stk_err <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stack_ctrl
// Purpose : Directed + randomized bench for stack_ctrl against a byte-level
//           stack model and a behavioural RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] push_data;
    logic        sp_wr_en;
    logic [7:0]  sp_wr_data;
    logic [7:0]  sp;
    logic        op_done;
    logic [15:0] pop_data;
    logic        stk_err;
    logic        ram_en;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  ram  [0:127];
    logic [7:0]  mref [0:127];
    logic [7:0]  msp;
    logic        merr;
    logic [15:0] mpop;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .push_data    (push_data),
        .sp_wr_en     (sp_wr_en),
        .sp_wr_data   (sp_wr_data),
        .sp           (sp),
        .op_done      (op_done),
        .pop_data     (pop_data),
        .stk_err      (stk_err),
        .ram_en       (ram_en),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_en && ram_write_en) ram[ram_addr] = ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic do_op(input logic [1:0] code, input logic [15:0] d);
        int         nb;
        logic [7:0] a;
        logic [7:0] b;
        op_valid  = 1'b1;
        op_code   = code;
        push_data = d;
        #1;
        chk("accept_ready", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        nb = code[1] ? 2 : 1;
        if (code == 2'b01) mpop[15:8] = 8'h00;
        for (int k = 0; k < nb; k++) begin
            if (!code[0]) begin
                a = msp + 8'd1;
                b = (k == 0) ? d[7:0] : d[15:8];
                chk("push_en",    ram_en, 1);
                chk("push_we",    ram_write_en, (a < 8'h80));
                chk("push_re",    ram_read_en, 0);
                chk("push_addr",  ram_addr, a[6:0]);
                chk("push_wdata", ram_wdata, b);
                if (a < 8'h80) mref[a[6:0]] = b;
                else merr = 1'b1;
                msp = a;
            end else begin
                a = msp;
                b = (a < 8'h80) ? mref[a[6:0]] : 8'h00;
                chk("pop_en",   ram_en, 1);
                chk("pop_re",   ram_read_en, (a < 8'h80));
                chk("pop_we",   ram_write_en, 0);
                chk("pop_addr", ram_addr, a[6:0]);
                if (nb == 2 && k == 0) mpop[15:8] = b;
                else mpop[7:0] = b;
                if (a >= 8'h80) merr = 1'b1;
                msp = a - 8'd1;
            end
            chk("busy_ready", op_ready, 0);
            chk("early_done", op_done, 0);
            @(negedge clk);
        end
        chk("op_done",    op_done, 1);
        chk("done_ram_en", ram_en, 0);
        @(negedge clk);
        chk("done_pulse", op_done, 0);
        chk("sp",         sp, msp);
        chk("pop_data",   pop_data, mpop);
        chk("stk_err",    stk_err, merr);
    endtask

    task automatic sp_wr(input logic [7:0] v, input logic with_op);
        sp_wr_en   = 1'b1;
        sp_wr_data = v;
        op_valid   = with_op;
        op_code    = 2'($urandom_range(3));
        push_data  = 16'($urandom);
        #1;
        chk("wr_ready", op_ready, 0);
        @(negedge clk);
        sp_wr_en = 1'b0;
        op_valid = 1'b0;
        msp  = v;
        merr = 1'b0;
        chk("wr_sp",   sp, v);
        chk("wr_err",  stk_err, 0);
        chk("wr_noop", ram_en, 0);
    endtask

    initial begin
        logic [7:0] v;
        rst_n      = 1'b0;
        op_valid   = 1'b0;
        op_code    = 2'b00;
        push_data  = 16'h0000;
        sp_wr_en   = 1'b0;
        sp_wr_data = 8'h00;
        for (int i = 0; i < 128; i++) begin
            mref[i] = 8'($urandom);
            ram[i]  = mref[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_sp",      sp, 8'h07);
        chk("rst_done",    op_done, 0);
        chk("rst_pop",     pop_data, 0);
        chk("rst_err",     stk_err, 0);
        chk("rst_ram_en",  ram_en, 0);
        chk("rst_ram_we",  ram_write_en, 0);
        chk("rst_ram_re",  ram_read_en, 0);
        rst_n = 1'b1;
        msp   = 8'h07;
        merr  = 1'b0;
        mpop  = 16'h0000;
        @(negedge clk);
        chk("idle_ready", op_ready, 1);

        do_op(2'b00, 16'h00A5);
        sp_wr(8'h07, 1'b0);
        do_op(2'b10, 16'h1234);
        do_op(2'b11, 16'h0000);
        chk("pop16_val", pop_data, 16'h1234);

        ram[8'h20]  = 8'h5A;
        mref[8'h20] = 8'h5A;
        sp_wr(8'h20, 1'b0);
        do_op(2'b01, 16'h0000);
        chk("pop8_val", pop_data, 16'h005A);

        sp_wr(8'h7F, 1'b0);
        do_op(2'b00, 16'h0011);
        chk("oor_push_err", stk_err, 1);
        do_op(2'b01, 16'h0000);
        chk("oor_pop_val", pop_data, 16'h0000);
        sp_wr(8'h30, 1'b0);

        // sp write and op request in the same idle cycle; op stays requested.
        sp_wr_en   = 1'b1;
        sp_wr_data = 8'h40;
        op_valid   = 1'b1;
        op_code    = 2'b00;
        push_data  = 16'h0077;
        #1;
        chk("prio_ready", op_ready, 0);
        @(negedge clk);
        sp_wr_en = 1'b0;
        msp  = 8'h40;
        merr = 1'b0;
        chk("prio_sp",   sp, 8'h40);
        chk("prio_noop", ram_en, 0);
        do_op(2'b00, 16'h0077);

        // Reset asserted during the high-byte cycle of a push16.
        sp_wr(8'h07, 1'b0);
        op_valid  = 1'b1;
        op_code   = 2'b10;
        push_data = 16'hBEEF;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mid_lo_we", ram_write_en, 1);
        mref[8] = 8'hEF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_hi_we", ram_write_en, 0);
        chk("mid_hi_en", ram_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        msp  = 8'h07;
        merr = 1'b0;
        mpop = 16'h0000;
        chk("mid_sp",    sp, 8'h07);
        chk("mid_done",  op_done, 0);
        chk("mid_ready", op_ready, 1);
        chk("mid_pop",   pop_data, 0);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(9) == 0) begin
                case ($urandom_range(6))
                    0: v = 8'h00;
                    1: v = 8'h7E;
                    2: v = 8'h7F;
                    3: v = 8'hFE;
                    4: v = 8'hFF;
                    5: v = 8'h40;
                    default: v = 8'($urandom);
                endcase
                sp_wr(v, 1'($urandom_range(1)));
            end else begin
                do_op(2'($urandom_range(3)), 16'($urandom));
            end
        end

        for (int i = 0; i < 128; i++) begin
            chk("ram_image", ram[i], mref[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
